// File: rtl/soc_pkg.sv
// soc_pkg: memory map and fetch types shared by the core's fetch and data-side decoders
package soc_pkg;
  typedef enum logic [1:0] {SRC_ROM, SRC_IMEM, SRC_FAULT} fetch_src_e;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
  localparam logic [31:0] ROM_BYTES  = 32'd512;
  localparam logic [31:0] IMEM_BASE  = 32'h1000_0000;
  localparam logic [31:0] IMEM_BYTES = 32'd4096;
endpackage

// File: rtl/fetch_addr_decode.sv
// fetch_addr_decode: classifies a fetch PC as ROM, IMEM or fault and forms region offsets
module fetch_addr_decode import soc_pkg::*; #(
  parameter logic [31:0] ROM_BASE   = soc_pkg::ROM_BASE,
  parameter logic [31:0] ROM_BYTES  = soc_pkg::ROM_BYTES,
  parameter logic [31:0] IMEM_BASE  = soc_pkg::IMEM_BASE,
  parameter logic [31:0] IMEM_BYTES = soc_pkg::IMEM_BYTES
) (
  input  logic [31:0] pc,
  output fetch_src_e  src,
  output logic [11:0] rom_off,
  output logic [11:0] imem_off
);
  logic [31:0] rom_rel, imem_rel;
  // unsigned offset compare covers both range bounds without a base >= 0 test
  always_comb begin
    rom_rel  = pc - ROM_BASE;
    imem_rel = pc - IMEM_BASE;
    rom_off  = rom_rel[11:0];
    imem_off = imem_rel[11:0];
    src      = (pc[1:0] != 2'b00) ? SRC_FAULT :
               (rom_rel < ROM_BYTES) ? SRC_ROM :
               (imem_rel < IMEM_BYTES) ? SRC_IMEM : SRC_FAULT;
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: two-stage fetch aligning ROM and IMEM to one cycle, with stall hold and redirect
module inst_fetch import soc_pkg::*; #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] ROM_BASE   = soc_pkg::ROM_BASE,
  parameter logic [31:0] ROM_BYTES  = soc_pkg::ROM_BYTES,
  parameter logic [31:0] IMEM_BASE  = soc_pkg::IMEM_BASE,
  parameter logic [31:0] IMEM_BYTES = soc_pkg::IMEM_BYTES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [11:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        imem_req_o,
  output logic [11:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_fault_o
);
  logic [31:0] pc_q, f2_pc, rom_q, hold_inst, mux_inst;
  logic        f2_valid, hold_valid, advance;
  fetch_src_e  src, f2_src;

  fetch_addr_decode #(
    .ROM_BASE(ROM_BASE), .ROM_BYTES(ROM_BYTES),
    .IMEM_BASE(IMEM_BASE), .IMEM_BYTES(IMEM_BYTES)
  ) u_dec (
    .pc(pc_q), .src(src), .rom_off(rom_addr_o), .imem_off(imem_addr_o)
  );

  always_comb begin
    advance    = !stall_i || !f2_valid;
    imem_req_o = advance && (src == SRC_IMEM) && !redirect_i;
    mux_inst   = hold_valid ? hold_inst :
                 (f2_src == SRC_ROM) ? rom_q :
                 (f2_src == SRC_IMEM) ? imem_rdata_i : NOP_INST;
    if_inst_o  = mux_inst;
    if_valid_o = f2_valid;
    if_pc_o    = f2_pc;
    if_fault_o = f2_valid && (f2_src == SRC_FAULT);
  end

  // IMEM data lives for one cycle only, so the first stalled cycle snapshots the output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      f2_valid   <= 1'b0;
      f2_pc      <= '0;
      f2_src     <= SRC_ROM;
      rom_q      <= '0;
      hold_valid <= 1'b0;
      hold_inst  <= '0;
    end else if (redirect_i) begin
      pc_q       <= redirect_pc_i;
      f2_valid   <= 1'b0;
      hold_valid <= 1'b0;
    end else if (advance) begin
      pc_q       <= pc_q + 32'd4;
      f2_valid   <= 1'b1;
      f2_pc      <= pc_q;
      f2_src     <= src;
      rom_q      <= rom_inst_i;
      hold_valid <= 1'b0;
    end else if (!hold_valid) begin
      hold_inst  <= mux_inst;
      hold_valid <= 1'b1;
    end
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage of the SoC core. It consumes the boot ROM and the on-chip instruction memory, and feeds the decode stage.
- Holds the PC and decodes the fetch address into one of three sources: ROM, IMEM, or fault.
- Aligns ROM data (combinational) and IMEM data (1-cycle synchronous) to a common 1-cycle latency.
- Presents one instruction per cycle to decode, with stall, hold and redirect support.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (boot ROM entry).
- ROM_BASE, 32'h0000_0000, ROM region base.
- ROM_BYTES, 512, ROM region size (128 words).
- IMEM_BASE, 32'h1000_0000, IMEM region base.
- IMEM_BYTES, 4096, IMEM region size.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- stall_i  in  1  decode cannot accept this cycle
- redirect_i  in  1  branch/jump taken
- redirect_pc_i  in  32  redirect target
- rom_addr_o  out  12  byte address to boot ROM
- rom_inst_i  in  32  ROM word (combinational from rom_addr_o)
- imem_req_o  out  1  IMEM read strobe
- imem_addr_o  out  12  IMEM byte offset
- imem_rdata_i  in  32  IMEM data, valid the cycle after imem_req_o
- if_valid_o  out  1  instruction valid to decode
- if_pc_o  out  32  PC of presented instruction
- if_inst_o  out  32  presented instruction
- if_fault_o  out  1  fetch access/misalign fault

Behaviour:
- Pipeline: F1 (pc_q, address issue) and F2 (f2_valid, f2_pc, f2_src, rom_q, hold_valid, hold_inst).
- Decode is combinational on pc_q:
  - ROM if ROM_BASE <= pc < ROM_BASE+ROM_BYTES.
  - IMEM if IMEM_BASE <= pc < IMEM_BASE+IMEM_BYTES.
  - FAULT otherwise, or if pc[1:0] != 0.
- Address outputs: rom_addr_o = pc_q[11:0] - ROM_BASE[11:0]; imem_addr_o = (pc_q - IMEM_BASE)[11:0]. Both are driven every cycle.
- advance = !stall_i || !f2_valid.
- imem_req_o = advance && src==IMEM && !redirect_i.
- On advance (no redirect):
  - f2_valid <= 1, f2_pc <= pc_q, f2_src <= src, rom_q <= rom_inst_i.
  - pc_q <= pc_q + 4, wrapping mod 2^32.
  - hold_valid <= 0.
- Output mux, in priority order:
  - if hold_valid: if_inst_o = hold_inst.
  - else by f2_src: ROM gives rom_q; IMEM gives imem_rdata_i; FAULT gives NOP 32'h0000_0013 with if_fault_o=1.
  - if_fault_o is 0 for ROM and IMEM sources.
- if_valid_o = f2_valid. if_pc_o = f2_pc.
- Stall: when stall_i && f2_valid && !hold_valid, capture the current mux output into hold_inst and set hold_valid <= 1. This covers IMEM data that is present for one cycle only. F1 and F2 do not change. Outputs stay stable for the whole stall.
- Redirect has the highest priority, over stall and advance:
  - pc_q <= redirect_pc_i, f2_valid <= 0, hold_valid <= 0.
  - No imem_req_o is issued that cycle.
  - The target instruction appears on if_valid_o 2 cycles after the redirect cycle.
- Fault does not halt fetch. The PC keeps incrementing; decode/trap logic is expected to redirect.
- Reset values (asynchronous, any cycle, including mid-stall or mid-redirect):
  - pc_q = RESET_PC.
  - f2_valid, hold_valid, if_valid_o, if_fault_o, imem_req_o = 0.
  - f2_pc, rom_q, hold_inst = 0, so if_pc_o = 0 and if_inst_o = 0 (f2_src = ROM).
  - rom_addr_o and imem_addr_o follow pc_q.
- First valid instruction: the second rising edge after reset_n deasserts.
- Throughput: 1 instruction/cycle with no stall and no redirect.

Decomposition:
- soc_pkg holds:
  - fetch_src_e {SRC_ROM, SRC_IMEM, SRC_FAULT}
  - NOP_INST = 32'h0000_0013
  - ROM_BASE / IMEM_BASE memory-map constants, shared with the data-side bus decoder.
- One sub-module: fetch_addr_decode (combinational: pc in; fetch_src_e, rom offset and imem offset out).

Test Plan:
- Boot: release reset with the real ROM attached.
  - Cycle 2: if_valid_o=1, pc 0x0, inst 0x1FC00113.
  - Next cycle: pc 0x4, inst 0x00000413.
  - Next cycle: pc 0x8, inst 0x20000493.
- Jump to IMEM: redirect_i to 0x1000_0000, IMEM model returns 0xDEADBEEF at offset 0 and 0x00A00093 at offset 4.
  - 2 cycles later: pc 0x1000_0000, inst 0xDEADBEEF, imem_addr_o 0x000.
  - Then pc 0x1000_0004, inst 0x00A00093.
- Stall on IMEM: hold stall_i 3 cycles while the pc 0x1000_0004 instruction is presented; the IMEM model drives garbage on non-request cycles.
  - if_inst_o stays 0x00A00093 and if_pc_o stays constant.
  - No new imem_req_o is issued.
  - After release, pc 0x1000_0008 follows.
- Fault cases:
  - Redirect to 0x3000_0000 → if_valid_o=1, if_fault_o=1, inst 0x00000013, imem_req_o never asserted.
  - Redirect to 0x0000_0002 → fault.
  - Redirect to 0x0000_0200 (past ROM end) → fault.
- Redirect during stall: stall_i=1 and redirect_i=1 to 0x0000_0010 together.
  - Next cycle: if_valid_o=0.
  - 2 cycles after the redirect cycle: pc 0x10, inst 0x0B4300E7.
- Reset mid-operation: assert reset_n low asynchronously between edges while fetching from IMEM under stall.
  - All outputs take their reset values immediately.
  - After release: pc 0x0, inst 0x1FC00113.
